cla_nibble_seq: RTL and testbench
=================================

Name: cla_nibble_seq

Overview:
- Multi-cycle 32-bit adder controller. It time-shares one 4-bit carry-lookahead slice across all nibbles of the operands, one nibble per clock, carrying between cycles through a register.
- Sits where a small-area add unit is wanted instead of the full 8-slice cascade.
- Valid/ready on input and output, so it drops into pipelines with backpressure.

Parameters:
- WIDTH, 32, operand/sum width; must be a positive multiple of 4.
- NSLICE, WIDTH/4, number of nibble steps per add; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A, sampled on acceptance only
- b  in  WIDTH  operand B, sampled on acceptance only
- c_in  in  1  carry into bit 0, sampled on acceptance only
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  a + b + c_in, low WIDTH bits
- c_out  out  1  carry out of bit WIDTH-1
- ovf  out  1  two's-complement overflow
- busy  out  1  high in RUN state

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst is high: state=IDLE; count, shift regs, carry reg and sum reg are all 0; out_valid=0, sum=0, c_out=0, ovf=0, busy=0, in_ready=0.
- After rst deasserts, in_ready follows the state rules below.
- States: IDLE, RUN, DONE.
- in_ready = (IDLE) or (DONE and out_ready). It is combinational from state and out_ready.
- Acceptance occurs on a rising edge with in_valid && in_ready. On acceptance:
  - a_sh<=a, b_sh<=b, carry<=c_in
  - msb_a<=a[WIDTH-1], msb_b<=b[WIDTH-1]
  - count<=0, state<=RUN
- RUN, on each edge:
  - The slice adds a_sh[3:0], b_sh[3:0] and carry.
  - sum_reg <= {slice_sum, sum_reg[WIDTH-1:4]}
  - carry <= slice carry-out
  - a_sh and b_sh shift right by 4
  - count++
  - When count==NSLICE-1: state<=DONE.
- Latency: out_valid rises exactly NSLICE edges after the accepting edge, i.e. 8 for the default.
- DONE:
  - out_valid=1, sum=sum_reg, c_out=carry.
  - ovf = (msb_a==msb_b) && (sum_reg[WIDTH-1]!=msb_a).
  - Outputs stay stable while out_ready=0.
  - On an edge with out_ready=1: if in_valid=1, accept new operands and go to RUN; otherwise go to IDLE.
- out_valid=0 in IDLE and RUN. The sum/c_out/ovf values are don't-care outside DONE, but must not be X after reset.
- Minimum issue interval is NSLICE+1 cycles, achieved through the DONE-to-RUN direct accept.
- Input changes after acceptance have no effect. in_valid during RUN is ignored and not queued.
- Carry chain wraps within the register only. There is no carry between separate operations; c_in is re-sampled on every accept.
- Reset asserted mid-RUN or mid-DONE: immediate abort, the result is discarded, no out_valid pulse.

Decomposition:
- Shared header holds state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
- Shared header also holds the slice width constant 4.
- One sub-module: the existing 4-bit lookahead slice CLA_4, instantiated once, combinational, between the shift regs and the carry/sum registers.
- The controller FSM, counter (clog2(NSLICE) bits) and shift regs live in cla_nibble_seq.

Test Plan:
- Carry through all nibbles: a=0x0000_0001, b=0xFFFF_FFFF, c_in=0 -> sum=0x0000_0000, c_out=1, ovf=0; out_valid rises exactly 8 edges after accept.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, c_in=0 -> sum=0x8000_0000, c_out=0, ovf=1.
- Carry-in honoured: a=0x1234_5678, b=0x0FED_CBA9, c_in=1 -> sum=0x2222_2222, c_out=0, ovf=0.
- All-ones case: a=b=0xFFFF_FFFF, c_in=1 -> sum=0xFFFF_FFFF, c_out=1, ovf=0.
- Backpressure, then back-to-back accept:
  - Hold out_ready=0 for 5 cycles in DONE -> sum/c_out/ovf stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 (a=2, b=3) -> same-edge accept, next result 5 after 8 more edges.
  - in_valid pulses during RUN are ignored.
- Reset mid-operation: assert rst asynchronously at count=3 -> state IDLE, out_valid=0, busy=0 with no clock needed. After release, in_ready=1, and a=10, b=20 yields 30 with correct latency.

Source files
------------

// File: rtl/cla_nibble_seq_pkg.sv
// rtl/cla_nibble_seq_pkg.sv - shared state encodings and slice width for the nibble-serial adder
package cla_nibble_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_nibble_seq_cla_4.sv
// rtl/cla_nibble_seq_cla_4.sv - combinational 4-bit carry-lookahead adder slice
module cla_nibble_seq_cla_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is formed directly from generate/propagate terms and c_in.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign sum   = p ^ c[3:0];
    assign c_out = c[4];

endmodule

// File: rtl/cla_nibble_seq.sv
// rtl/cla_nibble_seq.sv - multi-cycle adder sharing one 4-bit lookahead slice across all nibbles
module cla_nibble_seq
    import cla_nibble_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_reg;
    logic             carry;
    logic             msb_a;
    logic             msb_b;
    logic [3:0]       slice_sum;
    logic             slice_c;
    logic             accept;
    logic             done;

    cla_nibble_seq_cla_4 u_slice (
        .a     (a_sh[3:0]),
        .b     (b_sh[3:0]),
        .c_in  (carry),
        .sum   (slice_sum),
        .c_out (slice_c)
    );

    assign done     = (state == DONE);
    assign in_ready = !rst && ((state == IDLE) || (done && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = accept ? RUN : IDLE;
            RUN:     state_nxt = (count == LAST) ? DONE : RUN;
            DONE:    state_nxt = out_ready ? (in_valid ? RUN : IDLE) : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_reg <= '0;
            carry   <= 1'b0;
            msb_a   <= 1'b0;
            msb_b   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= c_in;
                msb_a <= a[WIDTH-1];
                msb_b <= b[WIDTH-1];
                count <= '0;
            end else if (state == RUN) begin
                // Result nibbles enter at the top, so after NSLICE steps nibble 0 sits at the bottom.
                sum_reg <= WIDTH'({slice_sum, sum_reg} >> SLICE_W);
                carry   <= slice_c;
                a_sh    <= a_sh >> SLICE_W;
                b_sh    <= b_sh >> SLICE_W;
                count   <= count + 1'b1;
            end
        end
    end

    assign out_valid = done;
    assign busy      = (state == RUN);
    assign sum       = done ? sum_reg : '0;
    assign c_out     = done & carry;
    assign ovf       = done & (msb_a == msb_b) & (sum_reg[WIDTH-1] != msb_a);

endmodule

// File: tb/tb_cla_nibble_seq.sv
// tb/tb_cla_nibble_seq.sv - scoreboard bench for the nibble-serial adder
module tb_cla_nibble_seq;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
    logic        busy;

    int   tests = 0;
    int   fails = 0;
    res_t sbq[$];
    res_t held;

    cla_nibble_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic ci);
        logic [32:0] t;
        res_t r;
        t   = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        r.s = t[31:0];
        r.c = t[32];
        r.v = (x[31] == y[31]) && (t[31] != x[31]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_op(input logic [31:0] x, input logic [31:0] y, input logic ci);
        int n = 0;
        while (!in_ready && n < 30) begin
            tick();
            n++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = x;
        b        = y;
        c_in     = ci;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        c_in     = 1'b0;
        sbq.push_back(model(x, y, ci));
    endtask

    task automatic wait_out(input string tag, input int start);
        int n = start;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'd8);
    endtask

    task automatic check_out(input string tag);
        res_t e;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_scoreboard observed empty expected entry", tag);
        end else begin
            e = sbq.pop_front();
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_sum"}, sum, e.s);
            chk({tag, "_cout"}, 32'(c_out), 32'(e.c));
            chk({tag, "_ovf"}, 32'(ovf), 32'(e.v));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_cout_ovf", {30'd0, c_out, ovf}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        accept_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        chk("run_busy", 32'(busy), 32'd1);
        wait_out("lat_carry_all", 0);
        check_out("carry_all");

        accept_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        wait_out("lat_ovf", 0);
        check_out("ovf");

        accept_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
        wait_out("lat_cin", 0);
        check_out("cin");

        accept_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_out("lat_ones", 0);
        check_out("ones");

        // In-RUN in_valid pulses must be ignored; then hold the result under backpressure.
        accept_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        out_ready = 1'b0;
        a         = 32'hDEAD_BEEF;
        b         = 32'h1111_1111;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
        chk("run_in_ready", 32'(in_ready), 32'd0);
        wait_out("lat_bp", 2);
        held = sbq[0];
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_sum", sum, held.s);
            chk("bp_flags", {29'd0, out_valid, c_out, ovf}, {29'd0, 1'b1, held.c, held.v});
            tick();
        end
        a         = 32'd2;
        b         = 32'd3;
        c_in      = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        check_out("bp");
        tick();
        in_valid = 1'b0;
        sbq.push_back(model(32'd2, 32'd3, 1'b0));
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_out("lat_b2b", 0);
        check_out("b2b");

        // Abort mid-RUN at count 3: asynchronous reset, the pending result is dropped.
        accept_op(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        void'(sbq.pop_front());
        tick();
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        accept_op(32'd10, 32'd20, 1'b0);
        wait_out("lat_after_abort", 0);
        check_out("after_abort");
        chk("queue_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
